// File: rtl/cell_drive_pkg.sv
// cell_drive_pkg
// Shared types for the cell drive arbiter: FSM state encoding, requester id
// and the 2-bit gate-input vector, plus the round-robin grant helper used
// by the arbiter's IDLE decode.
package cell_drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef logic       req_id_t;
    typedef logic [1:0] vec2_t;

    // One-hot grant for two requesters. On a tie the requester that was
    // not granted last wins; a lone requester always wins.
    function automatic vec2_t rr_grant(input vec2_t valid, input req_id_t last_id);
        vec2_t grant;
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_id ? 2'b01 : 2'b10;
        end
        return grant;
    endfunction

endpackage

// File: rtl/cell_drive_arbiter_sync2.sv
// sync2
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset, clears both flops
//   d      - asynchronous input
//   q      - synchronized output (two clk edges of latency)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cell_drive_arbiter.sv
// cell_drive_arbiter
// Arbitrates two requesters for a shared asynchronous logic cell. The winner's
// gate-input vector is driven onto the cell for SETTLE_CYC cycles, the
// synchronized cell output is sampled once and returned as a response that is
// held until the consumer accepts it.
//
// Parameters:
//   SETTLE_CYC - DRIVE duration in cycles (legal 2..15)
//   IDLE_VEC   - value on `in` while no operation is active
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_valid[1:0]       - request strobes, bit i = requester i
//   req_vec0, req_vec1   - proposed gate-input vectors
//   req_ready[1:0]       - one-hot acceptance, only in IDLE
//   in[1:0]              - shared cell gate-input bus
//   out                  - asynchronous cell output
//   rsp_valid/id/data    - response handshake toward the consumer
//   rsp_ready            - consumer acceptance
//   busy                 - high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | bus at IDLE_VEC, arbitrating requests
// DRIVE  | latched vector on the bus, settle counter running
// SAMPLE | capture synchronized cell output
// RESP   | response presented, waiting for rsp_ready
module cell_drive_arbiter
    import cell_drive_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 3,
    parameter logic [1:0]  IDLE_VEC   = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_vec0,
    input  logic [1:0] req_vec1,
    output logic [1:0] req_ready,
    output logic [1:0] in,
    input  logic       out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_data,
    input  logic       rsp_ready,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    vec2_t            vec_q, vec_d;
    req_id_t          id_q, id_d;
    req_id_t          last_q, last_d;
    logic             rsp_data_q, rsp_data_d;
    logic             armed_q, armed_d;
    logic             out_sync;
    vec2_t            grant;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (out),
        .q     (out_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vec_q      <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            rsp_data_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            id_q       <= id_d;
            last_q     <= last_d;
            rsp_data_q <= rsp_data_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        id_d       = id_q;
        last_d     = last_q;
        rsp_data_d = rsp_data_q;
        armed_d    = 1'b1;
        req_ready  = 2'b00;
        grant      = rr_grant(req_valid, last_q);

        case (state_q)
            ST_IDLE: begin
                // armed_q holds off grants for the first cycle after reset release
                if (armed_q) begin
                    req_ready = grant;
                end
                if (|(req_valid & req_ready)) begin
                    id_d    = req_ready[1];
                    last_d  = req_ready[1];
                    vec_d   = req_ready[1] ? req_vec1 : req_vec0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                rsp_data_d = out_sync;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign in        = busy ? vec_q : IDLE_VEC;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cell_drive_arbiter.sv
// Testbench for cell_drive_arbiter: directed scenarios and randomized traffic,
// all checked against a transaction-level model that tracks only the active
// operation, its age in cycles since acceptance, and the last granted id.
module tb_cell_drive_arbiter;

    localparam int S = 3;
    localparam logic [1:0] IV = 2'b01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_vec0 = 2'b00;
    logic [1:0] req_vec1 = 2'b00;
    logic [1:0] req_ready;
    logic [1:0] cell_in;
    logic       out = 1'b0;
    logic       rsp_valid;
    logic       rsp_id;
    logic       rsp_data;
    logic       rsp_ready = 1'b0;
    logic       busy;

    cell_drive_arbiter #(
        .SETTLE_CYC (S),
        .IDLE_VEC   (IV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_vec0  (req_vec0),
        .req_vec1  (req_vec1),
        .req_ready (req_ready),
        .in        (cell_in),
        .out       (out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    bit         m_active = 1'b0;
    int         m_age = 0;
    logic [1:0] m_vec = 2'b00;
    logic       m_id = 1'b0;
    logic       m_data = 1'b0;
    logic       m_last = 1'b1;

    // observations of the most recent cycle
    int         cyc = 0;
    int         obs_cyc;
    logic       obs_acc, obs_gid, obs_rsp, obs_rsp_id, obs_data, obs_busy;
    logic [1:0] obs_in, obs_ready;

    // One clock cycle: drive inputs (called just after posedge), check at negedge.
    task automatic cycle(input logic [1:0] v, input logic [1:0] v0, input logic [1:0] v1,
                         input logic o, input logic rr);
        int winner;
        logic [1:0] exp_ready;
        req_valid = v;
        req_vec0  = v0;
        req_vec1  = v1;
        out       = o;
        rsp_ready = rr;
        @(negedge clk);
        obs_cyc    = cyc;
        obs_acc    = |(req_valid & req_ready);
        obs_gid    = req_ready[1];
        obs_rsp    = rsp_valid;
        obs_rsp_id = rsp_id;
        obs_data   = rsp_data;
        obs_busy   = busy;
        obs_in     = cell_in;
        obs_ready  = req_ready;
        if (!m_active) begin
            exp_ready = 2'b00;
            chk("busy_idle", busy, 1'b0);
            chk("in_idle", cell_in, IV);
            chk("rsp_valid_idle", rsp_valid, 1'b0);
            if (v != 2'b00) begin
                if (v == 2'b11) winner = m_last ? 0 : 1;
                else winner = v[0] ? 0 : 1;
                exp_ready = (winner == 1) ? 2'b10 : 2'b01;
                m_active = 1'b1;
                m_age    = 1;
                m_id     = (winner == 1);
                m_last   = (winner == 1);
                m_vec    = (winner == 1) ? v1 : v0;
                m_data   = o;
            end
            chk("req_ready_idle", req_ready, exp_ready);
        end else begin
            chk("req_ready_busy", req_ready, 2'b00);
            chk("busy_active", busy, 1'b1);
            chk("in_active", cell_in, m_vec);
            if (m_age < S + 2) begin
                chk("rsp_valid_early", rsp_valid, 1'b0);
                m_age++;
            end else begin
                chk("rsp_valid_resp", rsp_valid, 1'b1);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, m_data);
                if (rr) m_active = 1'b0;
                else m_age++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        chk("rst_in", cell_in, IV);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_data", rsp_data, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("ready_first_cycle_after_release", req_ready, 2'b00);
        m_active = 1'b0;
        m_age    = 0;
        m_last   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic o);
        repeat (S + 6) cycle(2'b00, 2'b00, 2'b00, o, 1'b1);
    endtask

    int gids[$];
    int accs[$];
    int first_rsp;
    int acc_cyc;
    int n_in;
    int n_bad;
    int n_rsp;
    logic [1:0] v;
    logic cur_o;
    int hold;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();

        // tie, held requests: grants alternate starting with requester 0
        gids.delete();
        for (int i = 0; i < 4 * (S + 3); i++) begin
            cycle(2'b11, 2'b10, 2'b11, 1'b0, 1'b1);
            if (i == 0) chk("accept_second_cycle_after_reset", obs_acc, 1'b1);
            if (obs_acc) gids.push_back(int'(obs_gid));
        end
        chk("tie_count", gids.size(), 4);
        for (int i = 0; i < 4; i++) chk("tie_order", gids[i], i % 2);
        drain(1'b0);

        // single requester
        cycle(2'b01, 2'b10, 2'b00, 1'b1, 1'b1);
        chk("single_accept", obs_acc, 1'b1);
        acc_cyc   = obs_cyc;
        first_rsp = -1;
        n_in      = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
            if (obs_rsp && first_rsp < 0) first_rsp = obs_cyc;
            if (obs_busy && obs_in == 2'b10) n_in++;
        end
        chk("single_latency", first_rsp - acc_cyc, S + 2);
        chk("single_in_cycles", n_in, S + 2);

        // backpressure
        cycle(2'b01, 2'b00, 2'b11, 1'b0, 1'b0);
        chk("bp_accept", obs_acc, 1'b1);
        for (int i = 0; i < S + 2; i++) cycle(2'b11, 2'b00, 2'b11, 1'b0, 1'b0);
        chk("bp_rsp_valid", obs_rsp, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(2'b11, 2'b00, 2'b11, 1'b0, 1'b0);
            chk("bp_hold_valid", obs_rsp, 1'b1);
            chk("bp_hold_data", obs_data, 1'b0);
            chk("bp_hold_ready", obs_ready, 2'b00);
            chk("bp_hold_busy", obs_busy, 1'b1);
        end
        cycle(2'b11, 2'b00, 2'b11, 1'b0, 1'b1);
        chk("bp_complete_valid", obs_rsp, 1'b1);
        cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        chk("bp_after_busy", obs_busy, 1'b0);
        drain(1'b0);

        // withdrawn request from requester 1 while busy
        cycle(2'b01, 2'b11, 2'b00, 1'b1, 1'b1);
        chk("wd_accept", obs_acc, 1'b1);
        n_bad = 0;
        n_rsp = 0;
        cycle(2'b10, 2'b00, 2'b10, 1'b1, 1'b1);
        if (obs_acc) n_bad++;
        for (int i = 0; i < S + 8; i++) begin
            cycle(2'b00, 2'b00, 2'b10, 1'b1, 1'b1);
            if (obs_acc) n_bad++;
            if (obs_rsp && obs_rsp_id) n_bad++;
            if (obs_rsp) n_rsp++;
        end
        chk("wd_no_grant_or_rsp_for_1", n_bad, 0);
        chk("wd_rsp_count", n_rsp, 1);

        // back-to-back
        accs.delete();
        for (int i = 0; i < 4 * (S + 3); i++) begin
            cycle(2'b01, 2'($urandom_range(0, 3)), 2'b00, 1'b0, 1'b1);
            if (obs_acc) accs.push_back(obs_cyc);
        end
        chk("b2b_count", accs.size(), 4);
        for (int i = 1; i < accs.size(); i++) chk("b2b_spacing", accs[i] - accs[i-1], S + 3);
        drain(1'b0);

        // reset in the second DRIVE cycle
        cycle(2'b01, 2'b11, 2'b00, 1'b1, 1'b1);
        chk("mr_accept", obs_acc, 1'b1);
        cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        chk("mr_drive1_in", obs_in, 2'b11);
        do_reset();
        n_rsp = 0;
        for (int i = 0; i < S + 6; i++) begin
            cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
            if (obs_rsp) n_rsp++;
        end
        chk("mr_no_rsp_after_release", n_rsp, 0);

        // randomized traffic
        v     = 2'b00;
        cur_o = 1'b0;
        hold  = 0;
        for (int i = 0; i < 600; i++) begin
            logic rr;
            if ($urandom_range(0, 3) == 0) v = 2'($urandom_range(0, 3));
            if (!m_active) cur_o = 1'($urandom_range(0, 1));
            if (hold > 0) begin
                rr = 1'b0;
                hold--;
            end else if ($urandom_range(0, 15) == 0) begin
                rr   = 1'b0;
                hold = $urandom_range(3, 12);
            end else begin
                rr = ($urandom_range(0, 3) != 0);
            end
            cycle(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), cur_o, rr);
        end
        drain(cur_o);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_drive_arbiter.md
CELL_DRIVE_ARBITER -- requirements
Module: cell_drive_arbiter

Interface
REQ-001 Parameter SETTLE_CYC, default 3, SHALL set the cycles from driving `in` to sampling `out`; legal range 2..15.
REQ-002 Parameter IDLE_VEC, default 2'b00, SHALL set the value driven on `in` when no operation is active.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  2  SHALL carry the per-requester request strobe; bit i belongs to requester i.
REQ-006 req_vec0 / req_vec1  input  2 each  SHALL carry the gate-input vector proposed by requester 0 / 1.
REQ-007 req_ready  output  2  SHALL mark acceptance; at most one bit high per cycle.
REQ-008 in  output  2  SHALL drive the shared cell gate-input bus.
REQ-009 out  input  1  SHALL carry the asynchronous cell output.
REQ-010 rsp_valid  output  1  SHALL flag that a response is presented.
REQ-011 rsp_id  output  1  SHALL identify the requester that owns the response.
REQ-012 rsp_data  output  1  SHALL carry the sampled cell output.
REQ-013 rsp_ready  input  1  SHALL be the response consumer's acceptance.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, SAMPLE, RESP.
REQ-016 req_ready SHALL be nonzero only in IDLE.
REQ-017 In IDLE, req_ready SHALL go combinationally to the single valid requester.
REQ-018 In IDLE, if both requesters are valid, req_ready SHALL go to the requester not granted last (round-robin).
REQ-019 Acceptance SHALL be req_valid[i] & req_ready[i]; on acceptance: latch req_vec_i and id i, update the last-grant pointer, go to DRIVE.
REQ-020 Deasserting req_valid before acceptance SHALL be legal and SHALL leave no state behind.
REQ-021 In DRIVE, `in` SHALL equal the latched vector from the first DRIVE cycle until RESP is left.
REQ-022 DRIVE SHALL last exactly SETTLE_CYC cycles, timed by a down-counter of width clog2(SETTLE_CYC+1), then go to SAMPLE.
REQ-023 SAMPLE SHALL last one cycle and SHALL capture the 2-flop-synchronized `out` into rsp_data, then go to RESP.
REQ-024 rsp_valid SHALL assert exactly SETTLE_CYC+2 cycles after the accepting edge.
REQ-025 In RESP, rsp_valid, rsp_id and rsp_data SHALL stay stable until rsp_valid & rsp_ready.
REQ-026 On rsp_valid & rsp_ready, the FSM SHALL go to IDLE; the next acceptance is possible in the following cycle.
REQ-027 If rsp_ready is held low, the FSM SHALL remain in RESP indefinitely; no request SHALL be accepted.
REQ-028 `in` SHALL return to IDLE_VEC in IDLE.
REQ-029 Requests arriving while busy SHALL wait; none are dropped while req_valid is held.

Reset
REQ-030 While rst_n is low: state=IDLE, in=IDLE_VEC, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, synchronizer flops=0, counter=0, last-grant pointer=1 (requester 0 wins the first tie).
REQ-031 Reset asserted mid-operation SHALL abort the operation immediately, with no response emitted after release.
REQ-032 The first acceptance SHALL be possible in the second cycle after rst_n deasserts.

Structure
REQ-033 Package cell_drive_pkg SHALL hold the FSM state enum, the requester-id typedef and the 2-bit vector typedef.
REQ-034 The synchronizer SHALL be a separate sub-module, sync2 (1-bit, 2 flops, async active-low reset).

Verification
REQ-035 Single requester: req_valid=01, req_vec0=2'b10, out tied 1, SETTLE_CYC=3 -> in=10 for 3 DRIVE cycles plus SAMPLE/RESP; rsp_valid 5 cycles after accept; rsp_id=0, rsp_data=1.
REQ-036 Tie: req_valid=11 held, rsp_ready=1 -> grant order 0,1,0,1; rsp_id alternates.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=00, busy=1; completes on the first rsp_ready=1.
REQ-038 Reset mid-DRIVE: rst_n low in the 2nd DRIVE cycle -> in=IDLE_VEC and rsp_valid=0 immediately; no response after release.
REQ-039 Withdrawn request: req_valid[1] pulses for one cycle while busy -> no grant to 1, no response for 1.
REQ-040 Back-to-back: rsp_ready=1 permanently, req_valid=01 -> consecutive accepts exactly SETTLE_CYC+3 cycles apart; `in` shows IDLE_VEC for one cycle between operations.
